mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 9 +
 rtl/rr_arb2.sv | 15 +
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state type and default widths for mem_port_arbiter
package mem_arb_pkg;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 16;
  localparam int REQ_N      = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-way round-robin pick; last_gnt is held by the parent
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt,
  output logic       gnt_idx
);
  always_comb begin
    gnt_idx = 1'b0;
    if (req == 2'b11) gnt_idx = ~last_gnt;
    else if (req[1])  gnt_idx = 1'b1;
    gnt = 2'b00;
    if (req != 2'b00) gnt = gnt_idx ? 2'b10 : 2'b01;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester sequencer for the single-port on-chip buffer
// Optional grant counters are built when ARB_STATS_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
`ifdef ARB_STATS_EN
  ,
  parameter int CNT_W  = DEF_CNT_W
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_chipselect,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              busy
`ifdef ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]  gnt_cnt0,
  output logic [CNT_W-1:0]  gnt_cnt1
`endif
);
  arb_state_t        r_state, w_state_nxt;
  logic              r_last_gnt, r_idx, r_we;
  logic              r_cs, r_rd, r_wr, r_ack0, r_ack1, r_busy;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata0, r_rdata1;
  logic [REQ_N-1:0]  w_req, w_gnt;
  logic              w_gnt_idx, w_we_sel, w_issue, w_capture;

  assign w_req = {req1, req0};

  rr_arb2 u_rr_arb2 (
    .req      (w_req),
    .last_gnt (r_last_gnt),
    .gnt      (w_gnt),
    .gnt_idx  (w_gnt_idx)
  );

  assign w_we_sel = |(w_gnt & {we1, we0});

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: if (|w_req) begin
        w_issue     = 1'b1;
        w_state_nxt = ISSUE;
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        w_capture   = 1'b1;
        w_state_nxt = RESP;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last_gnt <= 1'b1;
      r_idx      <= 1'b0;
      r_we       <= 1'b0;
      r_cs       <= 1'b0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      // Strobes live for exactly the ISSUE cycle.
      r_cs    <= w_issue;
      r_rd    <= w_issue & ~w_we_sel;
      r_wr    <= w_issue & w_we_sel;
      r_ack0  <= w_capture & ~r_idx;
      r_ack1  <= w_capture & r_idx;
      if (w_issue) begin
        r_idx      <= w_gnt_idx;
        r_last_gnt <= w_gnt_idx;
        r_we       <= w_we_sel;
        r_addr     <= w_gnt_idx ? addr1 : addr0;
        r_wdata    <= w_gnt_idx ? wdata1 : wdata0;
      end
      if (w_capture && !r_we) begin
        if (r_idx) r_rdata1 <= mem_readdata;
        else       r_rdata0 <= mem_readdata;
      end
    end
  end

  assign mem_chipselect = r_cs;
  assign mem_read       = r_rd;
  assign mem_write      = r_wr;
  assign mem_address    = r_addr;
  assign mem_writedata  = r_wdata;
  assign ack0           = r_ack0;
  assign ack1           = r_ack1;
  assign rdata0         = r_rdata0;
  assign rdata1         = r_rdata1;
  assign busy           = r_busy;

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] r_gnt_cnt0, r_gnt_cnt1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt_cnt0 <= '0;
      r_gnt_cnt1 <= '0;
    end else begin
      if (w_issue && w_gnt[0] && !(&r_gnt_cnt0)) r_gnt_cnt0 <= r_gnt_cnt0 + 1'b1;
      if (w_issue && w_gnt[1] && !(&r_gnt_cnt1)) r_gnt_cnt1 <= r_gnt_cnt1 + 1'b1;
    end
  end

  assign gnt_cnt0 = r_gnt_cnt0;
  assign gnt_cnt1 = r_gnt_cnt1;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed bench for mem_port_arbiter with a behavioural buffer
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, mem_chipselect, mem_read, mem_write, busy;
  logic [DW-1:0] rdata0, rdata1, mem_writedata, mem_readdata;
  logic [AW-1:0] mem_address;
`ifdef ARB_STATS_EN
  logic [15:0]   gnt_cnt0, gnt_cnt1;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .req0           (req0),
    .we0            (we0),
    .addr0          (addr0),
    .wdata0         (wdata0),
    .ack0           (ack0),
    .rdata0         (rdata0),
    .req1           (req1),
    .we1            (we1),
    .addr1          (addr1),
    .wdata1         (wdata1),
    .ack1           (ack1),
    .rdata1         (rdata1),
    .mem_chipselect (mem_chipselect),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata),
    .busy           (busy)
`ifdef ARB_STATS_EN
    ,
    .gnt_cnt0       (gnt_cnt0),
    .gnt_cnt1       (gnt_cnt1)
`endif
  );

  // Behavioural 1024x32 buffer with registered read data; pl_* preloads it.
  logic [DW-1:0] mem [0:1023];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_chipselect && mem_write) mem[mem_address] <= mem_writedata;
    if (mem_chipselect && mem_read) mem_readdata <= mem[mem_address];
  end

  int n_ack0 = 0, n_ack1 = 0, n_overlap = 0;
  always @(negedge clk) begin
    if (ack0) n_ack0++;
    if (ack1) n_ack1++;
    if (mem_read && mem_write) n_overlap++;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  // Full transaction starting in an IDLE cycle T; returns at T+4.
  task automatic do_txn(input int id, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
    if (id == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; end
    else         begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; end
    tick();
    chk("issue_cs", mem_chipselect, 1);
    chk("issue_rd", mem_read, {31'd0, ~we});
    chk("issue_wr", mem_write, {31'd0, we});
    chk("issue_addr", mem_address, a);
    if (we) chk("issue_wdata", mem_writedata, wd);
    chk("issue_busy", busy, 1);
    tick();
    chk("wait_cs", mem_chipselect, 0);
    chk("wait_strobes", {mem_read, mem_write}, 0);
    chk("wait_ack", {ack1, ack0}, 0);
    tick();
    chk("resp_ack", {ack1, ack0}, (id == 0) ? 32'd1 : 32'd2);
    chk("resp_rdata", (id == 0) ? rdata0 : rdata1, exp_rd);
    if (id == 0) req0 = 1'b0; else req1 = 1'b0;
    tick();
    chk("post_ack", {ack1, ack0}, 0);
    chk("post_busy", busy, 0);
  endtask

  initial begin
    preload(10'd1, 32'h1111_1111);
    preload(10'd2, 32'h2222_2222);
    preload(10'd3, 32'h3333_3333);
    preload(10'd5, 32'hDEAD_BEEF);
    chk("rst_strobes", {mem_chipselect, mem_read, mem_write}, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_wdata", mem_writedata, 0);
    chk("rst_ack", {ack1, ack0}, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Tie from reset: requester 0 first, then strict alternation.
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'd2;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("tie_addr", mem_address, (k % 2) ? 32'd2 : 32'd1);
      chk("tie_rd", mem_read, 1);
      tick();
      tick();
      chk("tie_ack", {ack1, ack0}, (k % 2) ? 32'd2 : 32'd1);
      chk("tie_rdata", (k % 2) ? rdata1 : rdata0, (k % 2) ? 32'h2222_2222 : 32'h1111_1111);
      tick();
      chk("tie_ack_low", {ack1, ack0}, 0);
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    do_txn(0, 1'b0, 10'd5, 32'h0, 32'hDEAD_BEEF);
    do_txn(1, 1'b1, 10'h3FF, 32'h1234_5678, 32'h2222_2222);
    do_txn(0, 1'b0, 10'h3FF, 32'h0, 32'h1234_5678);

    // Requester 0 held through three reads; address changes during RESP.
    req0 = 1'b1; we0 = 1'b0; addr0 = 10'd1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("b2b_addr", mem_address, k + 1);
      tick();
      tick();
      chk("b2b_ack", ack0, 1);
      chk("b2b_rdata", rdata0, (k == 0) ? 32'h1111_1111 : (k == 1) ? 32'h2222_2222 : 32'h3333_3333);
      if (k == 2) req0 = 1'b0; else addr0 = AW'(k + 2);
      tick();
      chk("b2b_ack_low", ack0, 0);
    end
`ifdef ARB_STATS_EN
    chk("cnt0", gnt_cnt0, 7);
    chk("cnt1", gnt_cnt1, 3);
`endif

    // Reset during WAIT aborts the read with no ack.
    req1 = 1'b1; we1 = 1'b0; addr1 = 10'd5;
    tick();
    tick();
    chk("abort_busy_wait", busy, 1);
    reset = 1'b1;
    tick();
    chk("abort_ack", {ack1, ack0}, 0);
    chk("abort_busy", busy, 0);
    chk("abort_strobes", {mem_chipselect, mem_read, mem_write}, 0);
    chk("abort_rdata", rdata0 | rdata1, 0);
    chk("abort_addr", mem_address, 0);
`ifdef ARB_STATS_EN
    chk("abort_cnt", {gnt_cnt1, gnt_cnt0}, 0);
`endif
    req1 = 1'b0;
    reset = 1'b0;
    tick();
    chk("abort_idle_ack", {ack1, ack0}, 0);
    do_txn(1, 1'b0, 10'd3, 32'h0, 32'h3333_3333);
`ifdef ARB_STATS_EN
    chk("cnt_after", {gnt_cnt1, gnt_cnt0}, 32'h0001_0000);
`endif

    chk("no_overlap", n_overlap, 0);
    chk("ack0_total", n_ack0, 7);
    chk("ack1_total", n_ack1, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
